return_axis_out: RTL and testbench

RETURN_AXIS_OUT -- requirements
Module: return_axis_out

---
 rtl/return_axis_out_if.sv | 10 +
 rtl/return_axis_out.sv | 79 +++++++
 tb/tb_return_axis_out.sv | 139 +++++++++++++
 3 files changed

// File: rtl/return_axis_out_if.sv
// return_axis_out_if: AXI-Stream bundle carrying the return path's output beats.
interface return_axis_out_if #(parameter int DATA_BYTES = 8);
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  modport master(output tdata, tkeep, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/return_axis_out.sv
// return_axis_out: buffers return words in a FWFT ring and emits them as AXI-Stream packets.
// Define RETURN_AXIS_OUT_STATS_EN to enable the packet_count counter (tied to 0 otherwise).
module return_axis_out #(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH = 16,
  parameter int STALL_SLACK = 4,
  localparam int LBW = $clog2(DATA_BYTES) + 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_BYTES*8-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [LBW-1:0]          in_last_bytes,
  output logic                    stall_out,
  return_axis_out_if.master       m_axis,
  output logic                    overflow,
  output logic [15:0]             packet_count
);
  typedef enum logic [1:0] {IDLE, ACTIVE, CLOSING} state_t;
  state_t state, state_nxt;
  logic [DATA_BYTES*8-1:0] mem_data [DEPTH];
  logic [DATA_BYTES-1:0]   mem_keep [DEPTH];
  logic                    mem_last [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic full, wr_en, rd_en;
  logic [LBW-1:0] nbytes;
  logic [DATA_BYTES-1:0] keep_in;
  assign full = count == CW'(DEPTH);
  assign wr_en = in_valid && !full;
  assign rd_en = m_axis.tvalid && m_axis.tready;
  assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
  assign nbytes = in_last_bytes == '0 ? LBW'(DATA_BYTES) : in_last_bytes;
  always_comb
    for (int i = 0; i < DATA_BYTES; i++) keep_in[i] = !in_last || (i < int'(nbytes));
  assign m_axis.tvalid = count != '0;
  assign m_axis.tdata = mem_data[rd_ptr];
  assign m_axis.tkeep = mem_keep[rd_ptr];
  assign m_axis.tlast = mem_last[rd_ptr];
  // CLOSING holds off upstream until the whole packet has left the buffer
  assign stall_out = (CW'(DEPTH) - count) <= CW'(STALL_SLACK) || state == CLOSING;
  always_ff @(posedge clk)
    if (wr_en) begin
      mem_data[wr_ptr] <= in_data;
      mem_keep[wr_ptr] <= keep_in;
      mem_last[wr_ptr] <= in_last;
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count_nxt;
      overflow <= overflow | (in_valid && full);
    end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && wr_en) state_nxt = in_last ? CLOSING : ACTIVE;
    if (state == ACTIVE && wr_en && in_last) state_nxt = CLOSING;
    if (state == CLOSING && rd_en && m_axis.tlast)
      state_nxt = (wr_en && in_last) ? CLOSING : (count_nxt != '0 ? ACTIVE : IDLE);
  end
`ifdef RETURN_AXIS_OUT_STATS_EN
  always_ff @(posedge clk)
    if (reset) packet_count <= '0;
    else if (rd_en && m_axis.tlast) packet_count <= packet_count + 16'd1;
`else
  assign packet_count = '0;
`endif
endmodule

// File: tb/tb_return_axis_out.sv
// tb_return_axis_out: scoreboard bench; stimulus queues expected beats, a monitor checks each transfer.
module tb_return_axis_out;
  logic clk = 0, reset = 1;
  logic [63:0] in_data = '0;
  logic in_valid = 0, in_last = 0;
  logic [3:0] in_last_bytes = '0;
  logic stall_out, overflow;
  logic [15:0] packet_count;
  int checks = 0, errors = 0;
  logic [72:0] sb[$];
  logic held = 0;
  logic [72:0] held_beat;
  return_axis_out_if #(.DATA_BYTES(8)) ax();
  return_axis_out #(.DATA_BYTES(8), .DEPTH(16), .STALL_SLACK(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_last_bytes(in_last_bytes), .stall_out(stall_out), .m_axis(ax),
    .overflow(overflow), .packet_count(packet_count));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (held && ax.tvalid) check("hold_stable", {ax.tdata, ax.tkeep, ax.tlast}, held_beat);
      if (ax.tvalid && ax.tready) begin
        if (sb.size() == 0) check("unexpected_beat", {ax.tdata, ax.tkeep, ax.tlast}, '0);
        else check("beat", {ax.tdata, ax.tkeep, ax.tlast}, sb.pop_front());
      end
      held = ax.tvalid && !ax.tready;
      held_beat = {ax.tdata, ax.tkeep, ax.tlast};
    end
  end
  task automatic write(input logic [63:0] d, input logic last, input logic [3:0] lb,
                       input logic [7:0] keep, input logic accept);
    in_data = d; in_valid = 1; in_last = last; in_last_bytes = lb;
    if (accept) sb.push_back({d, keep, last});
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sb.delete();
  endtask
  task automatic wait_empty();
    logic done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (sb.size() == 0 && !ax.tvalid) done = 1;
      else begin @(posedge clk); #1; end
    end
    check("drain_done", done, 1);
  endtask
  initial begin
    ax.tready = 0;
    @(posedge clk); #1;
    do_reset();
    check("rst_tvalid", ax.tvalid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stall", stall_out, 0);
    check("rst_pcount", packet_count, 0);
    // three-word packet, 3 valid bytes at the end
    ax.tready = 1;
    write(64'h0706050403020100, 0, 0, 8'hFF, 1);
    write(64'h0F0E0D0C0B0A0908, 0, 0, 8'hFF, 1);
    write(64'h1716151413121110, 1, 3, 8'h07, 1);
    wait_empty();
`ifdef RETURN_AXIS_OUT_STATS_EN
    check("pcount_1", packet_count, 1);
`else
    check("pcount_tied", packet_count, 0);
`endif
    check("idle_stall", stall_out, 0);
    // fill with tready low, stall at 12, overflow on 17th
    do_reset();
    ax.tready = 0;
    for (int k = 1; k <= 16; k++) begin
      write(64'hA000 + 64'(k), 0, 0, 8'hFF, 1);
      check($sformatf("stall_cnt%0d", k), stall_out, k >= 12);
    end
    check("ovf_before", overflow, 0);
    write(64'hDEAD, 0, 0, 8'hFF, 0);
    check("ovf_after", overflow, 1);
    ax.tready = 1;
    wait_empty();
    check("ovf_sticky", overflow, 1);
    // full buffer, write and transfer in the same edge
    do_reset();
    check("ovf_cleared", overflow, 0);
    ax.tready = 0;
    for (int k = 1; k <= 16; k++) write(64'hB000 + 64'(k), 0, 0, 8'hFF, 1);
    ax.tready = 1;
    write(64'hBEEF, 0, 0, 8'hFF, 0);
    check("ovf_simul", overflow, 1);
    check("stall_cnt15", stall_out, 1);
    wait_empty();
    // tready toggling during a 5-word packet
    do_reset();
    for (int i = 0; i < 30; i++) begin
      ax.tready = i[0];
      if (i < 5) begin
        in_data = 64'hC000 + 64'(i); in_valid = 1; in_last = i == 4; in_last_bytes = 5;
        sb.push_back({64'hC000 + 64'(i), i == 4 ? 8'h1F : 8'hFF, i == 4});
      end else begin
        in_valid = 0; in_last = 0;
      end
      @(posedge clk); #1;
    end
    ax.tready = 1;
    wait_empty();
    // in_last_bytes = 0 means full word; stall held until tlast leaves
    do_reset();
    ax.tready = 0;
    write(64'hD001, 0, 0, 8'hFF, 1);
    write(64'hD002, 1, 0, 8'hFF, 1);
    check("closing_stall", stall_out, 1);
    ax.tready = 1;
    @(posedge clk); #1;
    check("closing_stall_mid", stall_out, 1);
    @(posedge clk); #1;
    check("closing_stall_done", stall_out, 0);
    check("closing_empty", ax.tvalid, 0);
    // reset with six words buffered
    ax.tready = 0;
    for (int k = 0; k < 6; k++) write(64'hE000 + 64'(k), 0, 0, 8'hFF, 1);
    check("pre_rst_tvalid", ax.tvalid, 1);
    do_reset();
    check("post_rst_tvalid", ax.tvalid, 0);
    ax.tready = 1;
    write(64'hF00D, 1, 1, 8'h01, 1);
    wait_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
